// File: rtl/lp_pkg.sv
// Shared types and defaults for the LP (simplex) core stages: pivot-column,
// pivot-row, update and comparator.
package lp_pkg;

  localparam int LP_DATA_WIDTH   = 32;
  localparam int LP_LOG_MAX_COLS = 10;
  localparam int LP_IDX_W        = LP_LOG_MAX_COLS + 1;

  typedef logic signed [LP_DATA_WIDTH-1:0] lp_coef_t;
  typedef logic        [LP_IDX_W-1:0]      lp_idx_t;

  typedef enum logic [1:0] {
    LP_IDLE,
    LP_SCAN,
    LP_DONE,
    LP_ERR
  } lp_state_e;

endpackage

// File: rtl/lp_pivot_col_select_if.sv
// Control, objective-row stream and result bundle of the pivot-column stage.
interface lp_pivot_col_select_if #(
  parameter int DATA_WIDTH   = lp_pkg::LP_DATA_WIDTH,
  parameter int LOG_MAX_COLS = lp_pkg::LP_LOG_MAX_COLS
);
  localparam int IDX_W = LOG_MAX_COLS + 1;

  logic [IDX_W-1:0]             num_cols;
  logic                         pivot_col_valid;
  logic signed [DATA_WIDTH-1:0] s_tdata;
  logic                         s_tvalid;
  logic                         s_tlast;
  logic                         s_tready;
  logic                         pivot_col_done;
  logic                         pivot_col_stop;
  logic [IDX_W-1:0]             pivot_col_idx;
  logic signed [DATA_WIDTH-1:0] pivot_col_val;
  logic                         optimal;

  modport master (
    output num_cols, pivot_col_valid, s_tdata, s_tvalid, s_tlast,
    input  s_tready, pivot_col_done, pivot_col_stop, pivot_col_idx,
           pivot_col_val, optimal
  );

  modport slave (
    input  num_cols, pivot_col_valid, s_tdata, s_tvalid, s_tlast,
    output s_tready, pivot_col_done, pivot_col_stop, pivot_col_idx,
           pivot_col_val, optimal
  );
endinterface

// File: rtl/lp_signed_min_track.sv
// Registered running minimum with index. Clearing loads 0, so only strictly
// smaller (i.e. negative) values are ever captured; ties keep the first index.
module lp_signed_min_track #(
  parameter int DATA_WIDTH = lp_pkg::LP_DATA_WIDTH,
  parameter int IDX_W      = lp_pkg::LP_IDX_W
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic        [IDX_W-1:0]      din_idx,
  output logic signed [DATA_WIDTH-1:0] min_val,
  output logic        [IDX_W-1:0]      min_idx,
  output logic                         found
);

  logic take;

  // Both operands are declared signed, so this is a two's-complement compare.
  assign take = en && (din < min_val);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      min_val <= '0;
      min_idx <= '0;
      found   <= 1'b0;
    end else if (clr) begin
      min_val <= '0;
      min_idx <= '0;
      found   <= 1'b0;
    end else if (take) begin
      min_val <= din;
      min_idx <= din_idx;
      found   <= 1'b1;
    end
  end

endmodule

// File: rtl/lp_pivot_col_select.sv
// Pivot-column stage: scans the objective row and picks the most negative
// non-RHS coefficient as the entering column.
module lp_pivot_col_select
  import lp_pkg::*;
#(
  parameter int DATA_WIDTH   = LP_DATA_WIDTH,
  parameter int LOG_MAX_COLS = LP_LOG_MAX_COLS
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  lp_pivot_col_select_if.slave  bus
);

  localparam int IDX_W = LOG_MAX_COLS + 1;

  lp_state_e                    state_q, state_d;
  logic [IDX_W-1:0]             count_q;
  logic [IDX_W-1:0]             num_cols_q;
  logic                         done_q;
  logic [IDX_W-1:0]             idx_q;
  logic signed [DATA_WIDTH-1:0] val_q;
  logic                         optimal_q;

  logic                         beat;
  logic                         is_rhs;
  logic                         scan_start;
  logic                         scan_ok;
  logic signed [DATA_WIDTH-1:0] min_val;
  logic [IDX_W-1:0]             min_idx;
  logic                         found;

  assign beat       = (state_q == LP_SCAN) && bus.s_tvalid;
  assign is_rhs     = (count_q == num_cols_q - IDX_W'(1));
  assign scan_start = (state_q == LP_IDLE) && bus.pivot_col_valid &&
                      (bus.num_cols >= IDX_W'(2));
  assign scan_ok    = beat && bus.s_tlast && is_rhs;

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LP_IDLE: begin
        if (bus.pivot_col_valid)
          state_d = (bus.num_cols < IDX_W'(2)) ? LP_ERR : LP_SCAN;
      end
      LP_SCAN: begin
        if (beat) begin
          if (bus.s_tlast)  state_d = is_rhs ? LP_DONE : LP_ERR;
          else if (is_rhs)  state_d = LP_ERR;
        end
      end
      // Wait for the request level to drop so a stale valid cannot restart.
      LP_DONE: if (!bus.pivot_col_valid) state_d = LP_IDLE;
      LP_ERR:  state_d = LP_ERR;
      default: state_d = LP_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= LP_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count_q    <= '0;
      num_cols_q <= '0;
    end else if (scan_start) begin
      count_q    <= '0;
      num_cols_q <= bus.num_cols;
    end else if (beat) begin
      count_q    <= count_q + IDX_W'(1);
    end
  end

  // The RHS beat is never compared, so the tracker is final when tlast lands.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      done_q    <= 1'b0;
      idx_q     <= '0;
      val_q     <= '0;
      optimal_q <= 1'b0;
    end else begin
      done_q <= scan_ok;
      if (scan_ok) begin
        idx_q     <= min_idx;
        val_q     <= min_val;
        optimal_q <= ~found;
      end
    end
  end

  lp_signed_min_track #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_min_track (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (scan_start),
    .en      (beat && !is_rhs),
    .din     (bus.s_tdata),
    .din_idx (count_q),
    .min_val (min_val),
    .min_idx (min_idx),
    .found   (found)
  );

  assign bus.s_tready       = (state_q == LP_SCAN);
  assign bus.pivot_col_stop = (state_q == LP_ERR);
  assign bus.pivot_col_done = done_q;
  assign bus.pivot_col_idx  = idx_q;
  assign bus.pivot_col_val  = val_q;
  assign bus.optimal        = optimal_q;

endmodule

// File: tb/tb_lp_pivot_col_select.sv
// Randomized bench for lp_pivot_col_select against a behavioural model of the
// entering-column rule and stream-length checks.
module tb_lp_pivot_col_select;
  import lp_pkg::*;

  localparam int IDX_W = LP_IDX_W;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  lp_pivot_col_select_if bus_if ();

  lp_pivot_col_select dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus_if)
  );

  int n_checks   = 0;
  int n_pass     = 0;
  int done_count = 0;
  int done_base  = 0;

  lp_coef_t beats [32];
  lp_coef_t exp_val;
  int       exp_idx;
  bit       exp_opt;

  always @(posedge aclk) if (bus_if.pivot_col_done) done_count <= done_count + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    bus_if.num_cols        = '0;
    bus_if.pivot_col_valid = 1'b0;
    bus_if.s_tdata         = '0;
    bus_if.s_tvalid        = 1'b0;
    bus_if.s_tlast         = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, bus_if.s_tready, 0);
    check({tag, "_done"},  bus_if.pivot_col_done, 0);
    check({tag, "_stop"},  bus_if.pivot_col_stop, 0);
    check({tag, "_idx"},   bus_if.pivot_col_idx, 0);
    check({tag, "_val"},   bus_if.pivot_col_val, 0);
    check({tag, "_opt"},   bus_if.optimal, 0);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    idle_inputs();
    #1;
    check_all_zero("reset");
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // Reference: minimum of the non-RHS coefficients; a result only if negative,
  // then the first column holding that minimum.
  task automatic model(input int ncols);
    lp_coef_t mn;
    mn = 0;
    for (int k = 0; k < ncols - 1; k++) if (beats[k] < mn) mn = beats[k];
    exp_val = mn;
    exp_opt = (mn == 0);
    exp_idx = 0;
    if (!exp_opt)
      for (int k = ncols - 2; k >= 0; k--) if (beats[k] == mn) exp_idx = k;
  endtask

  // Runs one scan. ended_ok=1 means a done was observed; 0 means the stage
  // stopped on a malformed stream as expected.
  task automatic run_scan(input int ncols, input int nbeats, input int last_at,
                          input int gap, input bit drop_valid, output bit ended_ok);
    int err_at;
    int done_at;
    err_at  = -1;
    done_at = -1;
    if (ncols < 2) err_at = -2;
    else begin
      for (int k = 0; k < nbeats; k++) begin
        if (k == last_at) begin
          if (k == ncols - 1) done_at = k; else err_at = k;
          break;
        end else if (k == ncols - 1) begin
          err_at = k;
          break;
        end
      end
      model(ncols);
    end
    ended_ok  = 1'b0;
    done_base = done_count;

    @(negedge aclk);
    bus_if.num_cols        = IDX_W'(ncols);
    bus_if.pivot_col_valid = 1'b1;
    @(negedge aclk);
    bus_if.num_cols = IDX_W'($urandom_range(0, 15));
    if (err_at == -2) begin
      check("short_cols_stop", bus_if.pivot_col_stop, 1);
      check("short_cols_ready", bus_if.s_tready, 0);
      return;
    end
    check("scan_ready", bus_if.s_tready, 1);
    if (drop_valid) bus_if.pivot_col_valid = 1'b0;

    for (int k = 0; k < nbeats; k++) begin
      while (int'($urandom_range(0, 99)) < gap) @(negedge aclk);
      bus_if.s_tdata  = beats[k];
      bus_if.s_tvalid = 1'b1;
      bus_if.s_tlast  = (k == last_at);
      @(negedge aclk);
      bus_if.s_tvalid = 1'b0;
      bus_if.s_tlast  = 1'b0;
      if (k == err_at) begin
        check("err_stop", bus_if.pivot_col_stop, 1);
        check("err_ready", bus_if.s_tready, 0);
        check("err_no_done", bus_if.pivot_col_done, 0);
        return;
      end
      if (k == done_at) begin
        check("done_pulse", bus_if.pivot_col_done, 1);
        check("done_idx", bus_if.pivot_col_idx, IDX_W'(exp_idx));
        check("done_val", bus_if.pivot_col_val, exp_val);
        check("done_opt", bus_if.optimal, exp_opt);
        check("done_stop", bus_if.pivot_col_stop, 0);
        ended_ok = 1'b1;
        return;
      end
      check("scan_no_done", bus_if.pivot_col_done, 0);
    end
  endtask

  // Holds valid after done, then releases it back to IDLE.
  task automatic finish_scan(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      check("done_single_cycle", bus_if.pivot_col_done, 0);
      check("done_ready_low", bus_if.s_tready, 0);
    end
    check("done_count", done_count, done_base + 1);
    check("hold_idx", bus_if.pivot_col_idx, IDX_W'(exp_idx));
    check("hold_val", bus_if.pivot_col_val, exp_val);
    bus_if.pivot_col_valid = 1'b0;
    @(negedge aclk);
  endtask

  task automatic hold_err();
    bus_if.pivot_col_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_if.s_tdata  = lp_coef_t'($urandom);
      bus_if.s_tvalid = 1'b1;
      bus_if.s_tlast  = $urandom_range(0, 1) == 1;
      @(negedge aclk);
      check("err_sticky", bus_if.pivot_col_stop, 1);
      check("err_ready_low", bus_if.s_tready, 0);
    end
    check("err_done_count", done_count, done_base);
    do_reset();
  endtask

  task automatic load4(input int a, input int b, input int c, input int d);
    beats[0] = lp_coef_t'(a);
    beats[1] = lp_coef_t'(b);
    beats[2] = lp_coef_t'(c);
    beats[3] = lp_coef_t'(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int ncols, nbeats, last_at, kind;
    idle_inputs();
    do_reset();

    // Directed: basic selection, optimal case, tie to lowest index.
    load4(-3, -7, 2, 10);
    run_scan(4, 4, 3, 0, 1'b0, ok);
    check("t1_ok", ok, 1);
    finish_scan(1);

    load4(1, 0, 5, -9);
    run_scan(4, 4, 3, 0, 1'b0, ok);
    check("t2_ok", ok, 1);
    finish_scan(1);

    load4(-4, -4, -2, -4);
    beats[4] = 3;
    run_scan(5, 5, 4, 0, 1'b1, ok);
    check("t3_ok", ok, 1);
    check("t3_idx", bus_if.pivot_col_idx, 0);
    finish_scan(1);

    // Malformed: early tlast, missing tlast, too few columns.
    load4(-1, -2, 3, 0);
    run_scan(4, 3, 2, 0, 1'b0, ok);
    hold_err();
    load4(-1, -2, 3, 4);
    beats[4] = 5;
    run_scan(4, 5, -1, 0, 1'b0, ok);
    hold_err();
    run_scan(1, 0, -1, 0, 1'b0, ok);
    hold_err();

    // Gapped 8-column stream; valid held after done, then a fresh scan.
    for (int k = 0; k < 8; k++) beats[k] = lp_coef_t'(int'($urandom_range(0, 140)) - 40);
    beats[6] = -50;
    beats[7] = -1000;
    run_scan(8, 8, 7, 30, 1'b0, ok);
    check("t5_idx", bus_if.pivot_col_idx, 6);
    finish_scan(5);
    load4(2, -8, -9, 1);
    run_scan(4, 4, 3, 30, 1'b0, ok);
    check("t5_rescan_idx", bus_if.pivot_col_idx, 2);
    finish_scan(1);

    // Reset mid-scan, then a clean scan must ignore the aborted beats.
    done_base = done_count;
    @(negedge aclk);
    bus_if.num_cols        = IDX_W'(4);
    bus_if.pivot_col_valid = 1'b1;
    @(negedge aclk);
    bus_if.pivot_col_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus_if.s_tdata  = lp_coef_t'(-100 * (k + 1));
      bus_if.s_tvalid = 1'b1;
      @(negedge aclk);
    end
    bus_if.s_tvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    check_all_zero("midscan_reset");
    check("midscan_no_done", done_count, done_base);
    @(negedge aclk);
    aresetn = 1'b1;
    load4(3, -1, -2, 5);
    run_scan(4, 4, 3, 0, 1'b0, ok);
    check("t6_idx", bus_if.pivot_col_idx, 2);
    finish_scan(1);

    // Randomized scans, well-formed and malformed.
    for (int r = 0; r < 30; r++) begin
      ncols = $urandom_range(2, 12);
      for (int k = 0; k < 32; k++) begin
        if ($urandom_range(0, 3) == 0) beats[k] = lp_coef_t'($urandom);
        else beats[k] = lp_coef_t'(int'($urandom_range(0, 20)) - 10);
      end
      if ($urandom_range(0, 9) == 0) beats[$urandom_range(0, ncols - 1)] = lp_coef_t'(32'h8000_0000);
      kind = $urandom_range(0, 7);
      if (kind == 0) begin
        last_at = $urandom_range(0, ncols - 2);
        nbeats  = last_at + 1;
      end else if (kind == 1) begin
        last_at = -1;
        nbeats  = ncols + 1;
      end else if (kind == 2) begin
        ncols   = $urandom_range(0, 1);
        last_at = -1;
        nbeats  = 0;
      end else begin
        last_at = ncols - 1;
        nbeats  = ncols;
      end
      run_scan(ncols, nbeats, last_at, $urandom_range(0, 40), $urandom_range(0, 1) == 1, ok);
      if (ok) finish_scan($urandom_range(1, 3));
      else hold_err();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
